hazard_scoreboard: RTL

- Parametrised hazard unit for the pipelined MIPS core; sits beside the decoder at the D stage.
- Tracks in-flight register writers in the post-decode stages with Tnew/Tuse counters and tracks a multi-cycle mul/div unit.
- Raises stall and selects D-stage bypass sources.
- Generalises the fixed per-stage "register read required" logic to STAGES pipeline slots and variable producer/consumer latencies.

---
 rtl/hazard_scoreboard.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks in-flight register writers and the mul/div unit,
// raises stall and selects the D-stage bypass source for rs/rt.
module hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int REG_W      = 5,
  parameter int T_W        = 2,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int FS_W       = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_dst,
  input  logic [T_W-1:0]   issue_tnew,
  input  logic [REG_W-1:0] rs_addr,
  input  logic [REG_W-1:0] rt_addr,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic [T_W-1:0]   rs_tuse,
  input  logic [T_W-1:0]   rt_tuse,
  input  logic             uses_md,
  input  logic             md_start,
  input  logic             md_is_div,
  output logic             stall,
  output logic [FS_W-1:0]  fwd_sel_rs,
  output logic [FS_W-1:0]  fwd_sel_rt,
  output logic             md_busy
);

  localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [REG_W-1:0]  dst_q  [STAGES];
  logic [REG_W-1:0]  dst_d  [STAGES];
  logic [T_W-1:0]    tnew_q [STAGES];
  logic [T_W-1:0]    tnew_d [STAGES];
  logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
  logic              md_busy_q;

  logic [STAGES-1:0] rs_match_s, rt_match_s;
  logic              rs_hit_s, rt_hit_s;
  logic [FS_W-1:0]   rs_code_s, rt_code_s;
  logic [T_W-1:0]    rs_tnew_s, rt_tnew_s;
  logic              rs_dstall_s, rt_dstall_s, md_stall_s, stall_s;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    logic [T_W-1:0] r;
    if (t == {T_W{1'b0}}) begin
      r = {T_W{1'b0}};
    end else begin
      r = t - T_W'(1);
    end
    return r;
  endfunction

  // Per-slot operand match; $0 and unread operands never match.
  always_comb begin
    rs_match_s = {STAGES{1'b0}};
    rt_match_s = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      rs_match_s[i] = vld_q[i] && (dst_q[i] == rs_addr) &&
                      (rs_addr != {REG_W{1'b0}}) && rs_used;
      rt_match_s[i] = vld_q[i] && (dst_q[i] == rt_addr) &&
                      (rt_addr != {REG_W{1'b0}}) && rt_used;
    end
  end

  // Priority pick: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    rs_hit_s  = 1'b0;
    rt_hit_s  = 1'b0;
    rs_code_s = {FS_W{1'b0}};
    rt_code_s = {FS_W{1'b0}};
    rs_tnew_s = {T_W{1'b0}};
    rt_tnew_s = {T_W{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      rs_hit_s  = rs_match_s[i] | rs_hit_s;
      rs_code_s = rs_match_s[i] ? FS_W'(i + 1) : rs_code_s;
      rs_tnew_s = rs_match_s[i] ? tnew_q[i] : rs_tnew_s;
      rt_hit_s  = rt_match_s[i] | rt_hit_s;
      rt_code_s = rt_match_s[i] ? FS_W'(i + 1) : rt_code_s;
      rt_tnew_s = rt_match_s[i] ? tnew_q[i] : rt_tnew_s;
    end
  end

  // Stall and bypass select, evaluated on the current (possibly frozen) slots.
  always_comb begin
    rs_dstall_s = rs_hit_s && (rs_tnew_s > rs_tuse);
    rt_dstall_s = rt_hit_s && (rt_tnew_s > rt_tuse);
    md_stall_s  = uses_md && (md_busy_q || md_start);
    stall_s     = issue_valid && (rs_dstall_s || rt_dstall_s || md_stall_s);
    if (rs_hit_s && (rs_tnew_s == {T_W{1'b0}}) && !stall_s) begin
      fwd_sel_rs = rs_code_s;
    end else begin
      fwd_sel_rs = {FS_W{1'b0}};
    end
    if (rt_hit_s && (rt_tnew_s == {T_W{1'b0}}) && !stall_s) begin
      fwd_sel_rt = rt_code_s;
    end else begin
      fwd_sel_rt = {FS_W{1'b0}};
    end
  end

  assign stall   = stall_s;
  assign md_busy = md_busy_q;

  // Slot advance and mul/div countdown; the countdown ignores hold.
  always_comb begin
    vld_d  = vld_q;
    dst_d  = dst_q;
    tnew_d = tnew_q;
    if (!hold) begin
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        dst_d[i]  = dst_q[i-1];
        tnew_d[i] = sat_dec(tnew_q[i-1]);
      end
      if (issue_valid && !stall_s && (issue_dst != {REG_W{1'b0}})) begin
        vld_d[0]  = 1'b1;
        dst_d[0]  = issue_dst;
        tnew_d[0] = issue_tnew;
      end else begin
        vld_d[0]  = 1'b0;
        dst_d[0]  = {REG_W{1'b0}};
        tnew_d[0] = {T_W{1'b0}};
      end
    end else begin
      vld_d  = vld_q;
      dst_d  = dst_q;
      tnew_d = tnew_q;
    end

    if (md_start) begin
      md_cnt_d = md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MUL_CYCLES);
    end else if (md_cnt_q != {MD_W{1'b0}}) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end else begin
      md_cnt_d = {MD_W{1'b0}};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q     <= {STAGES{1'b0}};
      md_cnt_q  <= {MD_W{1'b0}};
      md_busy_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        dst_q[i]  <= {REG_W{1'b0}};
        tnew_q[i] <= {T_W{1'b0}};
      end
    end else begin
      vld_q     <= vld_d;
      md_cnt_q  <= md_cnt_d;
      md_busy_q <= (md_cnt_d != {MD_W{1'b0}});
      for (int i = 0; i < STAGES; i++) begin
        dst_q[i]  <= dst_d[i];
        tnew_q[i] <= tnew_d[i];
      end
    end
  end

endmodule
